// File: rtl/rr_packet_arbiter_if.sv
// rr_packet_arbiter_if: request/grant bundle between input channels and one output-port arbiter.
interface rr_packet_arbiter_if #(
  parameter int NUMBER_CHANNELS = 5,
  parameter int IDX_W = 3
);
  logic [NUMBER_CHANNELS-1:0] req;
  logic [NUMBER_CHANNELS-1:0] last;
  logic                       ready;
  logic [NUMBER_CHANNELS-1:0] gnt;
  logic                       gnt_valid;
  logic [IDX_W-1:0]           gnt_idx;
  logic [NUMBER_CHANNELS-1:0] ack;
  logic                       xfer;
  logic                       abort;
  modport master (input req, last, ready, output gnt, gnt_valid, gnt_idx, ack, xfer, abort);
  modport slave (output req, last, ready, input gnt, gnt_valid, gnt_idx, ack, xfer, abort);
endinterface

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin arbiter that locks a grant for a whole packet, with a stall watchdog.
module rr_packet_arbiter #(
  parameter int NUMBER_CHANNELS = 5,
  parameter int IDX_W = 3,
  parameter int IDLE_LIMIT = 15
) (
  input logic clk,
  input logic rst,
  rr_packet_arbiter_if.master bus
);
  localparam int N = NUMBER_CHANNELS;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, nxt;
  logic [N-1:0] gnt_q, gnt_d;
  logic [7:0] stall_q, stall_d;
  logic abort_q, abort_d;
  logic own_req, xfer, tail, wd;

  function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    int j;
    w = p;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) j -= N;
      if (r[j]) w = IDX_W'(j);
    end
    return w;
  endfunction

  assign own_req = bus.req[idx_q];
  assign nxt = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
  assign xfer = (state_q == LOCKED) & own_req & bus.ready;
  assign tail = xfer & bus.last[idx_q];
  assign wd = (state_q == LOCKED) & ~own_req & (stall_q == 8'(IDLE_LIMIT - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end

  // Tail with any request re-arbitrates from w+1; w itself is scanned last, so it only wins when alone.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    stall_d = '0;
    abort_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = |bus.req ? LOCKED : IDLE;
      idx_d   = |bus.req ? pick(bus.req, ptr_q) : idx_q;
    end else if (tail) begin
      ptr_d   = nxt;
      state_d = |bus.req ? LOCKED : IDLE;
      idx_d   = |bus.req ? pick(bus.req, nxt) : idx_q;
    end else if (wd) begin
      ptr_d   = nxt;
      abort_d = 1'b1;
      state_d = IDLE;
    end else if (!own_req) begin
      stall_d = stall_q + 1'b1;
    end
    gnt_d = (state_d == LOCKED) ? N'(1) << idx_d : '0;
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.gnt_valid = (state_q == LOCKED);
    bus.gnt_idx   = idx_q;
    bus.abort     = abort_q;
    bus.ack       = gnt_q & {N{bus.ready}};
    bus.xfer      = xfer;
  end
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb_rr_packet_arbiter: random and directed stimulus scored against a packet-level arbitration model.
module tb_rr_packet_arbiter;
  localparam int N = 5;
  localparam int IDX_W = 3;
  localparam int LIMIT = 15;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic gv;
    logic [IDX_W-1:0] idx;
    logic ab;
    logic xf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int owner = -1;
  int ptr = 0;
  int stall = 0;
  int idx_m = 0;
  bit ab_m = 1'b0;

  rr_packet_arbiter_if #(.NUMBER_CHANNELS(N), .IDX_W(IDX_W)) bus ();
  rr_packet_arbiter #(.NUMBER_CHANNELS(N), .IDX_W(IDX_W), .IDLE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int pick_m(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = r;
    bus.last = l;
    bus.ready = rd;
    e.gnt = '0;
    if (owner >= 0) e.gnt[owner] = 1'b1;
    e.ack = rd ? e.gnt : '0;
    e.gv = (owner >= 0);
    e.idx = IDX_W'(idx_m);
    e.ab = ab_m;
    e.xf = (owner >= 0) && r[owner] && rd;
    q.push_back(e);
    ab_m = 1'b0;
    if (owner < 0) begin
      if (r != 0) begin
        owner = pick_m(r, ptr);
        idx_m = owner;
        stall = 0;
      end
    end else if (e.xf && l[owner]) begin
      ptr = (owner + 1) % N;
      stall = 0;
      if (r != 0) begin
        owner = pick_m(r, ptr);
        idx_m = owner;
      end else owner = -1;
    end else if (!r[owner]) begin
      stall++;
      if (stall == LIMIT) begin
        ptr = (owner + 1) % N;
        ab_m = 1'b1;
        owner = -1;
        stall = 0;
      end
    end else stall = 0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    checks++;
    if (bus.gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_locked gnt_valid=%b required=1", bus.gnt_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.abort} !== '0) begin
      errors++;
      $display("FAIL async_reset gnt=%b gnt_valid=%b gnt_idx=%0d abort=%b required all zero",
               bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.abort);
    end
    owner = -1;
    ptr = 0;
    stall = 0;
    idx_m = 0;
    ab_m = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    bit ok;
    if (rst) begin
      if (q.size() != 0) void'(q.pop_front());
    end else begin
      ok = bus.gnt_valid ? $onehot(bus.gnt) : (bus.gnt == '0);
      checks++;
      assert (ok) else begin
        errors++;
        $display("FAIL onehot gnt=%b gnt_valid=%b", bus.gnt, bus.gnt_valid);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        a.gnt = bus.gnt;
        a.ack = bus.ack;
        a.gv = bus.gnt_valid;
        a.idx = bus.gnt_idx;
        a.ab = bus.abort;
        a.xf = bus.xfer;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got gnt=%b ack=%b gv=%b idx=%0d abort=%b xfer=%b required gnt=%b ack=%b gv=%b idx=%0d abort=%b xfer=%b",
                   $time, a.gnt, a.ack, a.gv, a.idx, a.ab, a.xf, e.gnt, e.ack, e.gv, e.idx, e.ab, e.xf);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r, l;
    logic rd;
    bus.req = '0;
    bus.last = '0;
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    cycle(5'b00100, '0, 1'b1);
    cycle(5'b00100, '0, 1'b1);
    cycle(5'b00100, '0, 1'b1);
    cycle(5'b00100, 5'b00100, 1'b1);
    repeat (2) cycle('0, '0, 1'b1);
    for (int k = 0; k < 13; k++) cycle('1, (k % 2 == 1) ? '1 : '0, 1'b1);
    repeat (3) cycle(5'b00010, '0, 1'b1);
    repeat (2) cycle(5'b00011, '0, 1'b1);
    cycle(5'b00011, '1, 1'b1);
    repeat (2) cycle('0, '0, 1'b1);
    for (int k = 0; k < 20; k++) cycle(5'b01000, '0, k[0]);
    cycle(5'b01000, '1, 1'b1);
    cycle(5'b01000, '0, 1'b1);
    cycle(5'b01000, '0, 1'b1);
    repeat (18) cycle('0, '0, 1'b1);
    cycle('1, '0, 1'b1);
    for (int ph = 0; ph < 12; ph++) begin
      if (ph == 6) begin
        cycle('1, '0, 1'b0);
        mid_reset();
        cycle('1, '0, 1'b1);
        cycle('1, '0, 1'b1);
      end
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < N; b++) begin
          r[b] = (ph % 3 == 1) ? ($urandom % 16 == 0) : ($urandom % 4 != 0);
          l[b] = ($urandom % 3 == 0);
        end
        rd = (ph % 3 == 2) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
        cycle(r, l, rd);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
